// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Passive checker on the two-road signal-head bus (one-hot RED=001,
// YELLOW=010, GREEN=100). Follows each road's colour sequence, measures
// phase dwell in 1-second ticks, flags encoding/conflict/sequence/timing
// violations and counts completed road1+road2 signal cycles.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   enable          monitor enable (0: no checks, trackers parked at RED)
//   tick            1-second strobe, one clk wide
//   road1_in        road 1 light, one-hot
//   road2_in        road 2 light, one-hot
//   clr_err         clears err_flags and first_err_vld
//   err_flags       sticky flags [0] ENC [1] CONFLICT [2] SEQ [3] SHORT [4] TIMEOUT
//   err_pulse       one-cycle pulse for every detecting cycle
//   first_err       index of the first error since the last clear
//   first_err_vld   first_err is valid
//   dwell           ticks elapsed in the current phase (saturating)
//   cycle_cnt       completed road1+road2 cycles (saturating)
module traffic_light_monitor #(
    parameter int unsigned DW      = 6,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned YEL_MIN = 1,
    parameter int unsigned YEL_MAX = 3,
    parameter int unsigned GRN_MIN = 9,
    parameter int unsigned GRN_MAX = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             tick,
    input  logic [2:0]       road1_in,
    input  logic [2:0]       road2_in,
    input  logic             clr_err,
    output logic [4:0]       err_flags,
    output logic             err_pulse,
    output logic [2:0]       first_err,
    output logic             first_err_vld,
    output logic [DW-1:0]    dwell,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int unsigned NUM_ERR = 5;
    localparam int unsigned E_ENC   = 0;
    localparam int unsigned E_CONF  = 1;
    localparam int unsigned E_SEQ   = 2;
    localparam int unsigned E_SHORT = 3;
    localparam int unsigned E_TMO   = 4;

    localparam logic [2:0] LT_RED = 3'b001;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b100;

    typedef enum logic [1:0] {
        TRK_RED   = 2'd0,
        TRK_Y_UP  = 2'd1,
        TRK_GREEN = 2'd2,
        TRK_Y_DN  = 2'd3
    } trk_t;

    trk_t                 trk1_q, trk2_q, trk1_d, trk2_d;
    logic [2:0]           prev1_q, prev2_q, prev1_d, prev2_d;
    logic [DW-1:0]        dwell_d;
    logic                 enc_bad_c;
    logic                 in_chg_c;
    logic [NUM_ERR-1:0]   det_c;
    logic [NUM_ERR-1:0]   err_flags_d;
    logic [2:0]           first_err_d;
    logic                 first_err_vld_d;
    logic [CNT_W-1:0]     cycle_cnt_d;

    // Colour a tracker state shows on the signal head.
    function automatic logic [2:0] colour_of(input trk_t s);
        case (s)
            TRK_RED:   colour_of = LT_RED;
            TRK_GREEN: colour_of = LT_GRN;
            default:   colour_of = LT_YEL;
        endcase
    endfunction

    function automatic logic is_onehot(input logic [2:0] x);
        is_onehot = (x == LT_RED) || (x == LT_YEL) || (x == LT_GRN);
    endfunction

    // Legal colour changes only; "same colour" is handled by the caller.
    function automatic logic is_legal(input trk_t s, input logic [2:0] c);
        is_legal = ((s == TRK_RED)   && (c == LT_YEL)) ||
                   ((s == TRK_Y_UP)  && (c == LT_GRN)) ||
                   ((s == TRK_GREEN) && (c == LT_YEL)) ||
                   ((s == TRK_Y_DN)  && (c == LT_RED));
    endfunction

    // Tracker follows the driven colour; illegal changes adopt it too.
    function automatic trk_t trk_step(input trk_t s, input logic [2:0] c);
        trk_step = s;
        if (c != colour_of(s)) begin
            if (c == LT_RED)
                trk_step = TRK_RED;
            else if (c == LT_GRN)
                trk_step = TRK_GREEN;
            else
                trk_step = (s == TRK_GREEN) ? TRK_Y_DN : TRK_Y_UP;
        end
    endfunction

    function automatic logic short_bad(input trk_t s, input logic [2:0] c,
                                       input logic [DW-1:0] d);
        logic [2:0] oc;
        oc = colour_of(s);
        short_bad = (c != oc) &&
                    (((oc == LT_YEL) && (d < DW'(YEL_MIN))) ||
                     ((oc == LT_GRN) && (d < DW'(GRN_MIN))));
    endfunction

    // Fires on the tick that would carry dwell past the maximum; dwell
    // steps past the limit on that same tick, so it cannot repeat in a phase.
    function automatic logic timeout_bad(input trk_t s, input logic [2:0] c,
                                         input logic [DW-1:0] d, input logic t);
        timeout_bad = t && (c == colour_of(s)) &&
                      (((c == LT_YEL) && (d == DW'(YEL_MAX))) ||
                       ((c == LT_GRN) && (d == DW'(GRN_MAX))));
    endfunction

    function automatic logic [2:0] lowest_idx(input logic [NUM_ERR-1:0] v);
        lowest_idx = 3'd0;
        for (int i = NUM_ERR - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = 3'(i);
        end
    endfunction

    assign enc_bad_c = !is_onehot(road1_in) || !is_onehot(road2_in);
    assign in_chg_c  = {road1_in, road2_in} != {prev1_q, prev2_q};

    // State register: trackers, previous inputs, dwell.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trk1_q  <= TRK_RED;
            trk2_q  <= TRK_RED;
            prev1_q <= LT_RED;
            prev2_q <= LT_RED;
            dwell   <= '0;
        end else begin
            trk1_q  <= trk1_d;
            trk2_q  <= trk2_d;
            prev1_q <= prev1_d;
            prev2_q <= prev2_d;
            dwell   <= dwell_d;
        end
    end

    // Next state: an encoding error freezes trackers, dwell and previous inputs.
    always_comb begin
        trk1_d  = trk1_q;
        trk2_d  = trk2_q;
        prev1_d = prev1_q;
        prev2_d = prev2_q;
        dwell_d = dwell;
        if (!enable) begin
            trk1_d  = TRK_RED;
            trk2_d  = TRK_RED;
            prev1_d = road1_in;
            prev2_d = road2_in;
            dwell_d = '0;
        end else if (!enc_bad_c) begin
            trk1_d  = trk_step(trk1_q, road1_in);
            trk2_d  = trk_step(trk2_q, road2_in);
            prev1_d = road1_in;
            prev2_d = road2_in;
            if (in_chg_c)
                dwell_d = '0;
            else if (tick && (dwell != '1))
                dwell_d = dwell + DW'(1);
        end
    end

    // Output decode: error detection, sticky flags, first-error capture, cycle count.
    always_comb begin
        det_c           = '0;
        err_flags_d     = clr_err ? '0 : err_flags;
        first_err_d     = first_err;
        first_err_vld_d = clr_err ? 1'b0 : first_err_vld;
        cycle_cnt_d     = cycle_cnt;
        if (enable) begin
            if (enc_bad_c) begin
                det_c[E_ENC] = 1'b1;
            end else begin
                det_c[E_CONF]  = (road1_in != LT_RED) && (road2_in != LT_RED);
                det_c[E_SEQ]   = ((road1_in != colour_of(trk1_q)) && !is_legal(trk1_q, road1_in)) ||
                                 ((road2_in != colour_of(trk2_q)) && !is_legal(trk2_q, road2_in));
                det_c[E_SHORT] = short_bad(trk1_q, road1_in, dwell) ||
                                 short_bad(trk2_q, road2_in, dwell);
                det_c[E_TMO]   = timeout_bad(trk1_q, road1_in, dwell, tick) ||
                                 timeout_bad(trk2_q, road2_in, dwell, tick);
                if ((trk2_q == TRK_Y_DN) && (road2_in == LT_RED) && (cycle_cnt != '1))
                    cycle_cnt_d = cycle_cnt + CNT_W'(1);
            end
        end
        err_flags_d = err_flags_d | det_c;
        if ((det_c != '0) && !first_err_vld_d) begin
            first_err_d     = lowest_idx(det_c);
            first_err_vld_d = 1'b1;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_flags     <= '0;
            err_pulse     <= 1'b0;
            first_err     <= '0;
            first_err_vld <= 1'b0;
            cycle_cnt     <= '0;
        end else begin
            err_flags     <= err_flags_d;
            err_pulse     <= (det_c != '0);
            first_err     <= first_err_d;
            first_err_vld <= first_err_vld_d;
            cycle_cnt     <= cycle_cnt_d;
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor
// Directed and random stimulus for traffic_light_monitor, compared every
// cycle against a colour/direction reference model. A second instance with a
// 2-bit cycle counter exposes counter saturation in a short run.
module tb_traffic_light_monitor;

    localparam int DW      = 6;
    localparam int CNT_W   = 16;
    localparam int CNT_W_S = 2;
    localparam int YEL_MIN = 1;
    localparam int YEL_MAX = 3;
    localparam int GRN_MIN = 9;
    localparam int GRN_MAX = 11;
    localparam int DW_SAT  = (2 ** DW) - 1;
    localparam int CNT_SAT = (2 ** CNT_W) - 1;
    localparam int CNT_SAT_S = (2 ** CNT_W_S) - 1;

    localparam logic [2:0] R = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b100;

    logic               clk = 1'b0;
    logic               rst_n, enable, tick, clr_err;
    logic [2:0]         road1_in, road2_in;
    logic [4:0]         err_flags, err_flags_s;
    logic               err_pulse, err_pulse_s;
    logic [2:0]         first_err, first_err_s;
    logic               first_err_vld, first_err_vld_s;
    logic [DW-1:0]      dwell, dwell_s;
    logic [CNT_W-1:0]   cycle_cnt;
    logic [CNT_W_S-1:0] cycle_cnt_s;

    always #5 clk = ~clk;

    traffic_light_monitor #(.DW(DW), .CNT_W(CNT_W), .YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX),
                            .GRN_MIN(GRN_MIN), .GRN_MAX(GRN_MAX)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick),
        .road1_in(road1_in), .road2_in(road2_in), .clr_err(clr_err),
        .err_flags(err_flags), .err_pulse(err_pulse), .first_err(first_err),
        .first_err_vld(first_err_vld), .dwell(dwell), .cycle_cnt(cycle_cnt)
    );

    traffic_light_monitor #(.DW(DW), .CNT_W(CNT_W_S), .YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX),
                            .GRN_MIN(GRN_MIN), .GRN_MAX(GRN_MAX)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick),
        .road1_in(road1_in), .road2_in(road2_in), .clr_err(clr_err),
        .err_flags(err_flags_s), .err_pulse(err_pulse_s), .first_err(first_err_s),
        .first_err_vld(first_err_vld_s), .dwell(dwell_s), .cycle_cnt(cycle_cnt_s)
    );

    // Reference model: colour index per road (0 red, 1 yellow, 2 green) plus
    // whether a yellow is heading towards green.
    int         m_col [2];
    bit         m_up [2];
    int         m_dwell;
    logic [2:0] m_prev [2];
    logic [4:0] m_flags;
    bit         m_pulse;
    int         m_first;
    bit         m_vld;
    int         m_cnt, m_cnt_s;

    int    checks = 0;
    int    errors = 0;
    string tag = "init";

    function automatic int col_idx(input logic [2:0] x);
        case (x)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string what, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [4:0] det;
        logic [2:0] cur [2];
        int nc, oc;
        bit legal;
        det = '0;
        cur[0] = road1_in;
        cur[1] = road2_in;
        if (!rst_n) begin
            m_col = '{0, 0};
            m_up = '{1'b0, 1'b0};
            m_dwell = 0;
            m_prev = '{R, R};
            m_flags = '0;
            m_pulse = 1'b0;
            m_first = 0;
            m_vld = 1'b0;
            m_cnt = 0;
            m_cnt_s = 0;
        end else begin
            if (!enable) begin
                m_col = '{0, 0};
                m_dwell = 0;
                m_prev = cur;
            end else if (col_idx(cur[0]) < 0 || col_idx(cur[1]) < 0) begin
                det[0] = 1'b1;
            end else begin
                if (cur[0] != R && cur[1] != R) det[1] = 1'b1;
                for (int r = 0; r < 2; r++) begin
                    nc = col_idx(cur[r]);
                    oc = m_col[r];
                    if (nc != oc) begin
                        if ((oc == 1 && m_dwell < YEL_MIN) || (oc == 2 && m_dwell < GRN_MIN))
                            det[3] = 1'b1;
                        legal = (oc == 0 && nc == 1) || (oc == 1 && m_up[r] && nc == 2) ||
                                (oc == 2 && nc == 1) || (oc == 1 && !m_up[r] && nc == 0);
                        if (!legal)
                            det[2] = 1'b1;
                        else if (r == 1 && nc == 0) begin
                            if (m_cnt < CNT_SAT) m_cnt++;
                            if (m_cnt_s < CNT_SAT_S) m_cnt_s++;
                        end
                        m_up[r] = (oc == 0);
                        m_col[r] = nc;
                    end else if (tick && ((nc == 1 && m_dwell == YEL_MAX) ||
                                          (nc == 2 && m_dwell == GRN_MAX))) begin
                        det[4] = 1'b1;
                    end
                end
                if (cur[0] != m_prev[0] || cur[1] != m_prev[1])
                    m_dwell = 0;
                else if (tick && m_dwell < DW_SAT)
                    m_dwell++;
                m_prev = cur;
            end
            if (clr_err) begin
                m_flags = '0;
                m_vld = 1'b0;
            end
            m_flags = m_flags | det;
            m_pulse = (det != '0);
            if (det != '0 && !m_vld) begin
                for (int i = 4; i >= 0; i--) if (det[i]) m_first = i;
                m_vld = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("err_flags", 32'(err_flags), 32'(m_flags));
        chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
        chk("first_err", 32'(first_err), 32'(m_first));
        chk("first_err_vld", 32'(first_err_vld), 32'(m_vld));
        chk("dwell", 32'(dwell), 32'(m_dwell));
        chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
        chk("cycle_cnt_s", 32'(cycle_cnt_s), 32'(m_cnt_s));
    endtask

    // One clock: drive, advance model, sample 1 time unit after the edge.
    task automatic cyc(input logic [2:0] a, input logic [2:0] b, input logic t, input logic c);
        road1_in = a;
        road2_in = b;
        tick = t;
        clr_err = c;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Enter a colour pair, then hold it for n ticks (one per clock).
    task automatic hold(input logic [2:0] a, input logic [2:0] b, input int n);
        cyc(a, b, 1'b0, 1'b0);
        repeat (n) cyc(a, b, 1'b1, 1'b0);
    endtask

    task automatic forced_cycle();
        cyc(Y, R, 0, 0); cyc(G, R, 0, 0); cyc(Y, R, 0, 0); cyc(R, R, 0, 0);
        cyc(R, Y, 0, 0); cyc(R, G, 0, 0); cyc(R, Y, 0, 0); cyc(R, R, 0, 0);
    endtask

    logic [2:0] ph_r1 [8];
    logic [2:0] ph_r2 [8];

    initial begin
        int ph;
        int thr;
        logic [2:0] a, b;
        ph_r1 = '{R, Y, G, Y, R, R, R, R};
        ph_r2 = '{R, R, R, R, R, Y, G, Y};

        rst_n = 1'b0; enable = 1'b1; tick = 1'b0; clr_err = 1'b0;
        road1_in = R; road2_in = R;

        tag = "reset";
        cyc(R, R, 0, 0);
        cyc(R, R, 0, 0);
        chk("flags0", 32'(err_flags), 32'd0);
        chk("cnt0", 32'(cycle_cnt), 32'd0);
        chk("vld0", 32'(first_err_vld), 32'd0);
        rst_n = 1'b1;

        tag = "legal_cycle";
        hold(Y, R, 2); hold(G, R, 10); hold(Y, R, 2); hold(R, R, 0);
        hold(R, Y, 2); hold(R, G, 10); hold(R, Y, 2); hold(R, R, 0);
        chk("flags", 32'(err_flags), 32'd0);
        chk("cnt", 32'(cycle_cnt), 32'd1);
        chk("dwell", 32'(dwell), 32'd0);

        tag = "encoding";
        cyc(R, R, 1, 0);
        cyc(R, R, 1, 0);
        cyc(3'b011, R, 0, 0);
        chk("flags", 32'(err_flags), 32'b00001);
        chk("first", 32'(first_err), 32'd0);
        chk("pulse", 32'(err_pulse), 32'd1);
        chk("dwell_held", 32'(dwell), 32'd2);
        cyc(R, R, 0, 0);
        chk("pulse_drop", 32'(err_pulse), 32'd0);
        chk("dwell_after", 32'(dwell), 32'd2);

        tag = "conflict_seq";
        cyc(R, R, 0, 1);
        chk("cleared", 32'(err_flags), 32'd0);
        cyc(G, Y, 0, 0);
        chk("flags", 32'(err_flags), 32'b00110);
        chk("first", 32'(first_err), 32'd1);
        cyc(R, R, 0, 1);
        cyc(R, R, 0, 1);

        tag = "short";
        hold(Y, R, 2); hold(G, R, 5);
        cyc(Y, R, 0, 0);
        chk("flags", 32'(err_flags), 32'b01000);
        chk("first", 32'(first_err), 32'd3);
        repeat (2) cyc(Y, R, 1, 0);
        cyc(R, R, 0, 1);

        tag = "timeout";
        cyc(R, Y, 0, 0);
        repeat (3) begin
            cyc(R, Y, 1, 0);
            chk("tmo_early", 32'(err_flags[4]), 32'd0);
        end
        cyc(R, Y, 1, 0);
        chk("tmo_set", 32'(err_flags[4]), 32'd1);
        chk("tmo_pulse", 32'(err_pulse), 32'd1);
        cyc(R, Y, 1, 0);
        chk("tmo_once", 32'(err_pulse), 32'd0);
        hold(R, G, 10); hold(R, Y, 2); hold(R, R, 0);
        chk("cnt", 32'(cycle_cnt), 32'd2);

        tag = "clear_race";
        cyc(3'b000, R, 0, 0);
        cyc(G, R, 0, 1);
        chk("flags", 32'(err_flags), 32'b00100);
        chk("first", 32'(first_err), 32'd2);
        chk("vld", 32'(first_err_vld), 32'd1);
        cyc(R, R, 0, 1);
        cyc(R, R, 0, 1);

        tag = "reset_mid_green";
        hold(Y, R, 1); hold(G, R, 3);
        rst_n = 1'b0;
        cyc(G, R, 0, 0);
        chk("flags", 32'(err_flags), 32'd0);
        chk("dwell", 32'(dwell), 32'd0);
        chk("cnt", 32'(cycle_cnt), 32'd0);
        chk("first", 32'(first_err), 32'd0);
        cyc(R, R, 0, 0);
        rst_n = 1'b1;

        tag = "disabled";
        enable = 1'b0;
        cyc(3'b111, G, 1, 0);
        cyc(G, Y, 1, 0);
        cyc(Y, R, 1, 0);
        chk("flags", 32'(err_flags), 32'd0);
        chk("pulse", 32'(err_pulse), 32'd0);
        chk("dwell", 32'(dwell), 32'd0);
        enable = 1'b1;
        cyc(R, R, 0, 0);

        tag = "saturate";
        repeat (5) forced_cycle();
        chk("cnt_main", 32'(cycle_cnt), 32'd5);
        chk("cnt_sat", 32'(cycle_cnt_s), 32'd3);
        cyc(R, R, 0, 1);

        tag = "random";
        ph = 0;
        for (int k = 0; k < 4000; k++) begin
            thr = (ph == 2 || ph == 6) ? 4 : 15;
            if ($urandom_range(0, 99) < thr)
                ph = (ph + 1) % 8;
            else if ($urandom_range(0, 99) < 2)
                ph = int'($urandom_range(0, 7));
            a = ph_r1[ph];
            b = ph_r2[ph];
            if ($urandom_range(0, 99) < 2) a = 3'($urandom);
            if ($urandom_range(0, 99) < 2) b = 3'($urandom);
            enable = ($urandom_range(0, 99) >= 2);
            rst_n = ($urandom_range(0, 499) != 0);
            cyc(a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
        end
        rst_n = 1'b1;
        enable = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
